// File: rtl/game_state_controller.sv
// game_state_controller: button debounce, menu/play/pause/respawn/victory/game-over
// sequencer with lives, level-scaled game tick and entity reset pulse generation.
`default_nettype none

module game_state_controller #(
  parameter int GRID_CELLS         = 100,
  parameter int DEBOUNCE_CYCLES    = 4,
  parameter int RESET_PULSE_CYCLES = 15,
  parameter int NUM_LIVES          = 3,
  parameter int NUM_LEVELS         = 8,
  parameter int LEN_PER_LEVEL      = 5,
  parameter int TICK_BASE          = 1000,
  parameter int TICK_STEP          = 100
) (
  input  logic                               i_clk,
  input  logic                               i_rst,
  input  logic                               i_start_button,
  input  logic                               i_pause_button,
  input  logic [$clog2(GRID_CELLS):0]        i_snake_length,
  input  logic                               i_halt_condition,
  output logic [2:0]                         o_ctrl_state,
  output logic                               o_system_active,
  output logic                               o_reset_pulse,
  output logic                               o_game_tick,
  output logic [$clog2(NUM_LIVES+1)-1:0]     o_lives,
  output logic [$clog2(NUM_LEVELS):0]        o_level
);

  localparam int LW   = $clog2(GRID_CELLS) + 1;
  localparam int LIVW = $clog2(NUM_LIVES + 1);
  localparam int LVW  = $clog2(NUM_LEVELS) + 1;
  localparam int TW0  = $clog2(LEN_PER_LEVEL * NUM_LEVELS + 1);
  localparam int CW   = (LW > TW0) ? LW : TW0;
  localparam int PW   = $clog2(RESET_PULSE_CYCLES + 1);
  localparam int TKW  = $clog2(TICK_BASE + 1);
  localparam int DBW  = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic [2:0] {
    S_MENU     = 3'd0,
    S_PLAYING  = 3'd1,
    S_PAUSED   = 3'd2,
    S_VICTORY  = 3'd3,
    S_GAMEOVER = 3'd4,
    S_RESPAWN  = 3'd5
  } state_t;

  // Index 0 = start button, index 1 = pause button.
  logic [1:0]     r_sync0;
  logic [1:0]     r_sync1;
  logic [1:0]     r_db;
  logic [1:0]     r_db_q;
  logic [1:0]     r_press;
  logic [DBW-1:0] r_db_cnt [2];

  state_t          r_state;
  logic [LIVW-1:0] r_lives;
  logic [LVW-1:0]  r_level;
  logic [CW-1:0]   r_thr;
  logic [PW-1:0]   r_pulse;
  logic [TKW-1:0]  r_tick_cnt;
  logic            r_tick;

  logic [TKW-1:0]  w_period_m1;
  logic [CW-1:0]   w_len;
  logic            w_start_press;
  logic            w_pause_press;

  assign w_period_m1   = TKW'(TICK_BASE) - TKW'(int'(r_level) * TICK_STEP) - TKW'(1);
  assign w_len         = CW'(i_snake_length);
  assign w_start_press = r_press[0];
  assign w_pause_press = r_press[1];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync0  <= '0;
      r_sync1  <= '0;
      r_db     <= '0;
      r_db_q   <= '0;
      r_press  <= '0;
      for (int b = 0; b < 2; b++) r_db_cnt[b] <= '0;
    end else begin
      r_sync0 <= {i_pause_button, i_start_button};
      r_sync1 <= r_sync0;
      r_db_q  <= r_db;
      r_press <= r_db & ~r_db_q;
      for (int b = 0; b < 2; b++) begin
        if (r_sync1[b] != r_db[b]) begin
          if (r_db_cnt[b] == DBW'(DEBOUNCE_CYCLES - 1)) begin
            r_db[b]     <= r_sync1[b];
            r_db_cnt[b] <= '0;
          end else begin
            r_db_cnt[b] <= r_db_cnt[b] + DBW'(1);
          end
        end else begin
          r_db_cnt[b] <= '0;
        end
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= S_MENU;
      r_lives    <= '0;
      r_level    <= '0;
      r_thr      <= CW'(LEN_PER_LEVEL);
      r_pulse    <= '0;
      r_tick_cnt <= '0;
      r_tick     <= 1'b0;
    end else begin
      // Default countdown; a trigger below overrides it with a fresh load.
      if (r_pulse != '0) r_pulse <= r_pulse - PW'(1);

      case (r_state)
        S_MENU: begin
          if (w_start_press) begin
            r_state <= S_PLAYING;
            r_lives <= LIVW'(NUM_LIVES);
            r_level <= '0;
            r_thr   <= CW'(LEN_PER_LEVEL);
            r_pulse <= PW'(RESET_PULSE_CYCLES);
          end
        end
        S_PLAYING: begin
          if (w_len >= CW'(GRID_CELLS)) begin
            r_state <= S_VICTORY;
          end else if (i_halt_condition) begin
            if (r_lives > LIVW'(1)) begin
              r_lives <= r_lives - LIVW'(1);
              r_state <= S_RESPAWN;
              r_pulse <= PW'(RESET_PULSE_CYCLES);
            end else begin
              r_lives <= '0;
              r_state <= S_GAMEOVER;
            end
          end else if (w_pause_press) begin
            r_state <= S_PAUSED;
          end
          // Thresholds advance one level per cycle, so no divider is needed.
          if (w_len >= r_thr && r_level < LVW'(NUM_LEVELS - 1)) begin
            r_level <= r_level + LVW'(1);
            r_thr   <= r_thr + CW'(LEN_PER_LEVEL);
          end
        end
        S_PAUSED: begin
          if (w_start_press)      r_state <= S_MENU;
          else if (w_pause_press) r_state <= S_PLAYING;
        end
        S_VICTORY, S_GAMEOVER: begin
          if (w_start_press) r_state <= S_MENU;
        end
        S_RESPAWN: begin
          if (r_pulse <= PW'(1)) r_state <= S_PLAYING;
        end
        default: r_state <= S_MENU;
      endcase

      r_tick <= 1'b0;
      if (r_state == S_PLAYING && r_pulse == '0) begin
        if (r_tick_cnt >= w_period_m1) begin
          r_tick     <= 1'b1;
          r_tick_cnt <= '0;
        end else begin
          r_tick_cnt <= r_tick_cnt + TKW'(1);
        end
      end else if (r_state != S_PAUSED) begin
        r_tick_cnt <= '0;
      end
    end
  end

  assign o_ctrl_state    = r_state;
  assign o_system_active = (r_state == S_PLAYING);
  assign o_reset_pulse   = (r_pulse != '0);
  assign o_game_tick     = r_tick;
  assign o_lives         = r_lives;
  assign o_level         = r_level;

endmodule

`default_nettype wire

// File: tb/tb_game_state_controller.sv
// tb_game_state_controller: directed self-checking bench for game_state_controller.
`default_nettype none

module tb_game_state_controller;

  localparam int ST_MENU     = 0;
  localparam int ST_PLAYING  = 1;
  localparam int ST_PAUSED   = 2;
  localparam int ST_VICTORY  = 3;
  localparam int ST_GAMEOVER = 4;
  localparam int ST_RESPAWN  = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_b = 1'b0;
  logic       pause_b = 1'b0;
  logic       halt = 1'b0;
  logic [7:0] len = 8'd4;
  logic [2:0] state;
  logic       active;
  logic       pulse;
  logic       tick;
  logic [1:0] lives;
  logic [3:0] level;

  int n_checks = 0;
  int n_errors = 0;
  int start_hold = 0;
  int pause_hold = 0;
  int n;
  int ticks_seen;
  int not_paused;

  always #5 clk = ~clk;

  game_state_controller #(
    .GRID_CELLS        (100),
    .DEBOUNCE_CYCLES   (4),
    .RESET_PULSE_CYCLES(15),
    .NUM_LIVES         (3),
    .NUM_LEVELS        (8),
    .LEN_PER_LEVEL     (5),
    .TICK_BASE         (20),
    .TICK_STEP         (2)
  ) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_start_button  (start_b),
    .i_pause_button  (pause_b),
    .i_snake_length  (len),
    .i_halt_condition(halt),
    .o_ctrl_state    (state),
    .o_system_active (active),
    .o_reset_pulse   (pulse),
    .o_game_tick     (tick),
    .o_lives         (lives),
    .o_level         (level)
  );

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one cycle; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    if (start_hold > 0) start_hold--; else start_b = 1'b0;
    if (pause_hold > 0) pause_hold--; else pause_b = 1'b0;
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) step();
  endtask

  task automatic press_start(input int hold);
    start_b    = 1'b1;
    start_hold = hold - 1;
  endtask

  task automatic press_pause(input int hold);
    pause_b    = 1'b1;
    pause_hold = hold - 1;
  endtask

  task automatic wait_state(input int target, input int limit, output int cnt);
    cnt = 0;
    while (int'(state) != target && cnt <= limit) begin
      step();
      cnt++;
    end
    if (int'(state) != target) cnt = -1;
  endtask

  task automatic wait_tick(input int limit, output int cnt);
    cnt = 0;
    do begin
      step();
      cnt++;
    end while (!tick && cnt < limit);
    if (!tick) cnt = -1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    idle(2);
    check_eq("rst_state", int'(state), ST_MENU);
    check_eq("rst_pulse", int'(pulse), 0);
    check_eq("rst_tick", int'(tick), 0);
    check_eq("rst_lives", int'(lives), 0);
    check_eq("rst_level", int'(level), 0);
    check_eq("rst_active", int'(active), 0);
    rst = 1'b0;
    idle(2);

    // Three-cycle glitch must not be accepted
    press_start(3);
    idle(15);
    check_eq("glitch_state", int'(state), ST_MENU);

    // Clean press: raw edge to state change is 2+4+1 cycles plus the FSM edge
    press_start(10);
    wait_state(ST_PLAYING, 20, n);
    check_eq("start_latency", n, 8);
    check_eq("start_active", int'(active), 1);
    check_eq("start_lives", int'(lives), 3);
    check_eq("start_level", int'(level), 0);
    n = 0;
    while (pulse && n < 40) begin
      step();
      n++;
    end
    check_eq("pulse_width", n, 15);

    // Level 0 period 20, first tick 20 cycles after the pulse drops
    wait_tick(40, n);
    check_eq("first_tick", n, 20);
    wait_tick(40, n);
    check_eq("tick_gap_l0", n, 20);

    // Pause with tick counter held at 7
    idle(19);
    press_pause(10);
    wait_state(ST_PAUSED, 20, n);
    check_eq("pause_latency", n, 8);
    halt = 1'b1;
    ticks_seen = 0;
    not_paused = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (tick) ticks_seen++;
      if (int'(state) != ST_PAUSED) not_paused++;
    end
    halt = 1'b0;
    check_eq("paused_ticks", ticks_seen, 0);
    check_eq("paused_stays", not_paused, 0);
    press_pause(10);
    wait_state(ST_PLAYING, 20, n);
    check_eq("unpause_latency", n, 8);
    wait_tick(40, n);
    check_eq("resume_tick", n, 13);

    // Level-up to 1, period 18
    len = 8'd5;
    step();
    check_eq("level1", int'(level), 1);
    wait_tick(40, n);
    wait_tick(40, n);
    check_eq("tick_gap_l1", n, 18);

    // Length jump: one level per cycle, saturate at 7, period 6
    len = 8'd40;
    step();
    check_eq("level_step", int'(level), 2);
    idle(5);
    check_eq("level7", int'(level), 7);
    idle(5);
    check_eq("level_sat", int'(level), 7);
    wait_tick(40, n);
    wait_tick(40, n);
    check_eq("tick_gap_l7", n, 6);

    // Two respawns
    for (int k = 0; k < 2; k++) begin
      halt = 1'b1;
      step();
      halt = 1'b0;
      check_eq("respawn_state", int'(state), ST_RESPAWN);
      check_eq("respawn_lives", int'(lives), 2 - k);
      check_eq("respawn_pulse", int'(pulse), 1);
      n = 0;
      while (int'(state) == ST_RESPAWN && n < 40) begin
        step();
        n++;
      end
      check_eq("respawn_len", n, 15);
      check_eq("respawn_exit", int'(state), ST_PLAYING);
      check_eq("respawn_pulse_off", int'(pulse), 0);
      check_eq("respawn_level", int'(level), 7);
    end

    // Last life
    halt = 1'b1;
    step();
    halt = 1'b0;
    check_eq("gameover_state", int'(state), ST_GAMEOVER);
    check_eq("gameover_lives", int'(lives), 0);
    check_eq("gameover_pulse", int'(pulse), 0);
    press_start(10);
    wait_state(ST_MENU, 20, n);
    check_eq("gameover_to_menu", n, 8);
    check_eq("menu_lives_held", int'(lives), 0);

    // Victory beats halt
    len = 8'd4;
    idle(20);
    press_start(10);
    wait_state(ST_PLAYING, 20, n);
    check_eq("restart", n, 8);
    check_eq("restart_lives", int'(lives), 3);
    check_eq("restart_level", int'(level), 0);
    len = 8'd100;
    halt = 1'b1;
    step();
    halt = 1'b0;
    len = 8'd4;
    check_eq("victory_state", int'(state), ST_VICTORY);
    check_eq("victory_lives", int'(lives), 3);
    check_eq("victory_active", int'(active), 0);
    idle(20);
    press_start(10);
    wait_state(ST_MENU, 20, n);
    check_eq("victory_to_menu", n, 8);

    // Simultaneous start and pause in PAUSED -> MENU
    idle(20);
    press_start(10);
    wait_state(ST_PLAYING, 20, n);
    idle(20);
    press_pause(10);
    wait_state(ST_PAUSED, 20, n);
    check_eq("pause2", n, 8);
    idle(20);
    press_start(10);
    press_pause(10);
    step();
    wait_state(ST_MENU, 20, n);
    check_eq("both_to_menu", n, 7);

    // Async reset in RESPAWN mid-pulse
    idle(20);
    press_start(10);
    wait_state(ST_PLAYING, 20, n);
    idle(20);
    halt = 1'b1;
    step();
    halt = 1'b0;
    check_eq("rsp_before_rst", int'(state), ST_RESPAWN);
    idle(5);
    rst = 1'b1;
    #1;
    check_eq("arst_state", int'(state), ST_MENU);
    check_eq("arst_pulse", int'(pulse), 0);
    check_eq("arst_lives", int'(lives), 0);
    check_eq("arst_level", int'(level), 0);
    check_eq("arst_active", int'(active), 0);
    check_eq("arst_tick", int'(tick), 0);
    step();
    rst = 1'b0;
    idle(5);
    check_eq("post_rst_state", int'(state), ST_MENU);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
